// File: rtl/apb_master_arb.sv
// Two-requester APB master: round-robin arbitration, SETUP/ACCESS sequencing,
// PREADY timeout and per-requester completion reporting.
module apb_master_arb #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              rq0_req,
  input  logic              rq0_write,
  input  logic [ADDR_W-1:0] rq0_addr,
  input  logic [DATA_W-1:0] rq0_wdata,
  output logic              rq0_gnt,
  output logic              rq0_done,
  output logic [DATA_W-1:0] rq0_rdata,
  output logic              rq0_err,
  input  logic              rq1_req,
  input  logic              rq1_write,
  input  logic [ADDR_W-1:0] rq1_addr,
  input  logic [DATA_W-1:0] rq1_wdata,
  output logic              rq1_gnt,
  output logic              rq1_done,
  output logic [DATA_W-1:0] rq1_rdata,
  output logic              rq1_err,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic                    prio_q, prio_d;    // requester favoured on contention
  logic                    owner_q, owner_d;  // requester owning the current transfer
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    psel_q, psel_d;
  logic                    penable_q, penable_d;
  logic                    pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]       paddr_q, paddr_d;
  logic [DATA_W-1:0]       pwdata_q, pwdata_d;
  logic [1:0]              gnt_q, gnt_d;
  logic [1:0]              done_q, done_d;
  logic [1:0]              err_q, err_d;
  logic [1:0][DATA_W-1:0]  rdata_q, rdata_d;
  logic                    win;

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    prio_d    = prio_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    gnt_d     = '0;
    done_d    = '0;
    err_d     = err_q;
    rdata_d   = rdata_q;
    win       = 1'b0;

    case (state_q)
      IDLE: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        if (rq0_req || rq1_req) begin
          win          = (rq0_req && rq1_req) ? prio_q : rq1_req;
          owner_d      = win;
          prio_d       = ~win;
          gnt_d[win]   = 1'b1;
          pwrite_d     = win ? rq1_write : rq0_write;
          paddr_d      = win ? rq1_addr  : rq0_addr;
          pwdata_d     = win ? rq1_wdata : rq0_wdata;
          cnt_d        = '0;
          psel_d       = 1'b1;
          state_d      = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (PREADY) begin
          done_d[owner_q] = 1'b1;
          err_d[owner_q]  = 1'b0;
          if (!pwrite_q) rdata_d[owner_q] = PRDATA;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          state_d   = IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          // Completer stalled too long: abort with error and zeroed data
          done_d[owner_q]  = 1'b1;
          err_d[owner_q]   = 1'b1;
          rdata_d[owner_q] = '0;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= IDLE;
      prio_q    <= 1'b0;
      owner_q   <= 1'b0;
      cnt_q     <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      err_q     <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      prio_q    <= prio_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
    end
  end

  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign rq0_gnt   = gnt_q[0];
  assign rq1_gnt   = gnt_q[1];
  assign rq0_done  = done_q[0];
  assign rq1_done  = done_q[1];
  assign rq0_err   = err_q[0];
  assign rq1_err   = err_q[1];
  assign rq0_rdata = rdata_q[0];
  assign rq1_rdata = rdata_q[1];

endmodule

// File: doc/apb_master_arb.md
Name: apb_master_arb

Overview:
- Two-port APB master arbiter. Shares one APB completer (such as the on-chip APB memory slave) between two requesters.
- Grants requesters round-robin, captures the winning request, and drives the APB SETUP/ACCESS sequence.
- Waits on PREADY, returns read data and completion status to the granted requester.
- Sits between bus-master logic and the APB slave, so completers never see PSEL/PENABLE sequencing errors.

Parameters:
ADDR_W, 32, PADDR and requester address width
DATA_W, 32, PWDATA/PRDATA and requester data width
TIMEOUT, 16, max ACCESS cycles with PREADY=0 before abort (range 1..255)

Ports:
PCLK  in  1  clock, all logic on rising edge
PRESETn  in  1  asynchronous active-low reset
rq0_req  in  1  requester 0 transfer request, held until rq0_gnt
rq0_write  in  1  1=write, 0=read
rq0_addr  in  ADDR_W  transfer address
rq0_wdata  in  DATA_W  write data
rq0_gnt  out  1  one-cycle pulse: request captured
rq0_done  out  1  one-cycle pulse: transfer finished
rq0_rdata  out  DATA_W  read data, valid with rq0_done
rq0_err  out  1  timeout flag, valid with rq0_done
rq1_req, rq1_write, rq1_addr, rq1_wdata, rq1_gnt, rq1_done, rq1_rdata, rq1_err: identical to rq0_*, for requester 1
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PWRITE  out  1  APB direction
PADDR  out  ADDR_W  APB address
PWDATA  out  DATA_W  APB write data
PRDATA  in  DATA_W  APB read data
PREADY  in  1  APB ready / wait state

Behaviour:
- Reset (PRESETn=0, asynchronous): state=IDLE. All outputs 0, including PADDR, PWDATA, rdata, gnt, done and err. Wait counter 0. Round-robin pointer favours rq0. Reset mid-transfer aborts immediately; no done pulse is issued afterwards.
- All outputs are registered.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - PSEL=0, PENABLE=0.
  - If any rqN_req=1, pick the winner, capture its write/addr/wdata into PWRITE/PADDR/PWDATA, pulse rqN_gnt next cycle, go to SETUP.
  - If neither request is asserted, stay in IDLE.
- Arbitration:
  - Single request: that requester wins.
  - Both requesting: the requester not granted last wins. After reset, rq0 wins first.
  - The pointer updates only on grant.
- SETUP: exactly one cycle. PSEL=1, PENABLE=0, PADDR/PWRITE/PWDATA stable. Always go to ACCESS.
- ACCESS:
  - PSEL=1, PENABLE=1; address, data and direction unchanged.
  - PREADY=1: on the next cycle pulse rqN_done, with rqN_err=0. For reads, register rqN_rdata=PRDATA; for writes, rqN_rdata holds its previous value. Go to IDLE; PSEL and PENABLE drop.
  - PREADY=0: increment the wait counter.
  - Timeout: when the counter reaches TIMEOUT with PREADY still 0, pulse rqN_done with rqN_err=1, set rqN_rdata=0, and go to IDLE.
  - Wait counter clears on every entry to SETUP.
- Latency with zero wait states, taking cycle 0 as the cycle the request is sampled in IDLE:
  - gnt and SETUP in cycle 1;
  - ACCESS in cycle 2;
  - done in cycle 3;
  - IDLE in cycle 3, earliest next grant in cycle 4.
  - Minimum 4 cycles per transfer; each PREADY=0 cycle adds one.
- Requester inputs are ignored outside the IDLE sampling cycle. After gnt, a requester may change addr/wdata freely.
- A req still high in IDLE after done is treated as a new request.
- The non-granted requester keeps waiting; its req must stay high. There is no cancellation.
- Ownership: only the granted requester's gnt, done, rdata and err ever change. The other requester's outputs hold.
- Mutual exclusion: at most one gnt and one done pulse per cycle.
- rdata and err hold their values until that requester's next done pulse.

Test Plan:
- Write, no wait: rq0 writes addr 0x10, data 0xDEADBEEF, PREADY=1 -> gnt cycle 1; PSEL=1/PENABLE=0 cycle 1; PENABLE=1 cycle 2; rq0_done=1, rq0_err=0 cycle 3; PADDR=0x10, PWDATA=0xDEADBEEF, PWRITE=1 throughout.
- Read with waits: rq1 reads addr 0x20, slave returns PRDATA=0x12345678 after 3 PREADY=0 cycles -> PENABLE held 4 cycles, rq1_done in cycle 6, rq1_rdata=0x12345678, rq1_err=0.
- Contention: rq0 and rq1 both assert continuously for 4 transfers -> grant order rq0, rq1, rq0, rq1; never two gnt in the same cycle; PSEL low for exactly one cycle between transfers.
- Timeout: TIMEOUT=4, PREADY held 0 -> ACCESS lasts 4 cycles, then rq0_done=1, rq0_err=1, rq0_rdata=0; FSM returns to IDLE and the next request is served normally.
- Reset mid-ACCESS: assert PRESETn=0 during the ACCESS cycle -> PSEL, PENABLE, gnt and done go 0 immediately without waiting for PCLK; after release the first contending grant goes to rq0.
- Late input change: rq0 changes addr 0x10->0x30 the cycle after gnt -> PADDR stays 0x10 until done.
